// File: rtl/serial_sub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Master drives start/a/b; slave returns busy/done/diff/borrow_out plus a state view for checkers.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  // valid/ready contract: start is a request seen only while busy is low; an accepted start
  // captures a and b on that edge, and done pulses for one cycle when diff/borrow_out are fresh.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic [1:0]       state_dbg;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, state_dbg
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, state_dbg
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b computed LSB first, one bit per clock,
// using a 1-bit subtract cell made of two half subtractors and an OR on the borrows.

module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic p
);
  assign d = x ^ y;
  assign p = ~x & y;
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d1, p1, p2, bit_d, bit_bout;
  logic [WIDTH:0]   result_ext;

  half_sub u_hs1 (.x(a_q[0]), .y(b_q[0]),   .d(d1),    .p(p1));
  half_sub u_hs2 (.x(d1),     .y(borrow_q), .d(bit_d), .p(p2));

  assign bit_bout   = p1 | p2;
  // New bit enters at the MSB; after WIDTH steps the first bit has reached bit 0.
  assign result_ext = {bit_d, result_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN:  if (count_q == LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.state_dbg = state_q;
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          count_d  = '0;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = result_ext[WIDTH:1];
        borrow_d = bit_bout;
        count_d  = count_q + CW'(1);
        // Results publish only on the final step so they stay stable everywhere else.
        if (count_q == LAST) begin
          diff_d = result_ext[WIDTH:1];
          bout_d = bit_bout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: a timeline model predicts accepted starts and the
// arithmetic result; a negedge monitor compares busy/done/diff/borrow_out every cycle.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sub_ctrl_if #(.WIDTH(W)) sif ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         edge_n  = 0;
  int         free_at = 0;
  bit         armed   = 1'b0;
  logic [W:0] held    = '0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h edge=%0d", name, act, req, edge_n);
    end
  endtask

  // Reference model: a start is taken only once the previous job's slot has fully elapsed.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      free_at = edge_n + 1;
      held    = '0;
      armed   = 1'b1;
    end else if (sif.start === 1'b1 && edge_n >= free_at) begin
      exp_q.push_back({1'b0, sif.a} - {1'b0, sif.b});
      acc_q.push_back(edge_n);
      free_at = edge_n + W + 2;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic busy_exp;
    logic done_exp;
    if (armed) begin
      busy_exp = (acc_q.size() > 0);
      done_exp = 1'b0;
      if (busy_exp) done_exp = (edge_n == acc_q[0] + W);
      chk("busy", {{W{1'b0}}, sif.busy}, {{W{1'b0}}, busy_exp});
      chk("done", {{W{1'b0}}, sif.done}, {{W{1'b0}}, done_exp});
      if (done_exp) begin
        held = exp_q.pop_front();
        void'(acc_q.pop_front());
      end
      chk("result", {sif.borrow_out, sif.diff}, held);
    end
  end

  task automatic pulse(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = av;
    sif.b     = bv;
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = W'($urandom);
    sif.b     = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    pulse(8'h5A, 8'h23); idle(11);
    pulse(8'h00, 8'h01); idle(11);
    pulse(8'h80, 8'h80); idle(11);
    pulse(8'hFF, 8'h00); idle(11);

    // start during RUN must be ignored
    pulse(8'h10, 8'h01); idle(2);
    pulse(8'h00, 8'hFF); idle(11);

    // reset mid-run discards the job; a fresh job afterwards completes normally
    pulse(8'h33, 8'h44); idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    pulse(8'hC3, 8'h3C); idle(11);

    // start held high with operands changing every cycle
    @(negedge clk);
    sif.start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sif.a = W'($urandom);
      sif.b = W'($urandom);
      @(negedge clk);
    end
    sif.start = 1'b0;
    idle(12);

    // random pulses and gaps
    for (int i = 0; i < 25; i++) begin
      pulse(W'($urandom), W'($urandom));
      idle($urandom_range(0, 12));
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending results", exp_q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
